ether_tx_frame_gen: RTL and testbench
=====================================

ETHER_TX_FRAME_GEN -- requirements
Module: ether_tx_frame_gen

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination MAC address.
REQ-002 SHALL have parameter SRC_MAC, default 48'h00_00_0C_00_53_00, source MAC address.
REQ-003 SHALL have parameter ETHER_TYPE, default 16'h88B5, EtherType field.
REQ-004 SHALL have parameter PAYLOAD_LEN, default 46, payload bytes; legal range 46..1500.
REQ-005 SHALL have parameter IFG_LEN, default 12, inter-frame gap in byte slots; minimum 12.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port clk, input, 1, the single clock, e.g. 125 MHz ether clock.
REQ-008 SHALL have port cke, input, 1, byte-slot enable; all state advances only when cke=1.
REQ-009 SHALL have port enable, input, 1, request to transmit frames continuously.
REQ-010 SHALL have port gmii_tx_en, output, 1, frame byte valid.
REQ-011 SHALL have port gmii_txd, output, 8, transmit byte.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port frame_count, output, 32, count of completed frames.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG.
REQ-015 SHALL move IDLE->PREAMBLE on a cke cycle with enable=1; otherwise SHALL stay in IDLE.
REQ-016 SHALL emit 7 bytes of 8'h55 in PREAMBLE, then 1 byte of 8'hD5 in SFD.
REQ-017 SHALL emit 14 header bytes in HEADER: DST_MAC MSB first, SRC_MAC MSB first, then ETHER_TYPE MSB first.
REQ-018 SHALL emit PAYLOAD_LEN bytes in PAYLOAD: bytes 0..3 = frame_count value at frame start, big-endian; byte i>=4 = i[7:0], wrapping modulo 256.
REQ-019 SHALL emit 4 FCS bytes: IEEE 802.3 CRC-32, reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, computed over header and payload, result inverted, sent least-significant byte first.
REQ-020 SHALL hold gmii_tx_en=1 from the first preamble byte through the last FCS byte, so each frame is 26+PAYLOAD_LEN consecutive cke slots.
REQ-021 SHALL hold gmii_tx_en=0 and gmii_txd=8'h00 in IFG for exactly IFG_LEN cke slots, and in IDLE.
REQ-022 SHALL, at the end of IFG, go to PREAMBLE if enable=1, else to IDLE, so that back-to-back frames are separated by exactly IFG_LEN slots.
REQ-023 SHALL complete any frame in progress when enable deasserts mid-frame; no truncation, IFG still applied.
REQ-024 SHALL register gmii_tx_en and gmii_txd, so that the first preamble byte appears one clk after the cke cycle on which IDLE sampled enable=1.
REQ-025 SHALL hold all outputs and state unchanged on cycles with cke=0.
REQ-026 SHALL increment frame_count by 1 in the cycle the last FCS byte is issued, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-027 SHALL use a byte counter wide enough for 1500 and clear it on every state transition.

Reset
REQ-028 SHALL take state IDLE while reset=1, and all outputs SHALL read 0: gmii_tx_en, gmii_txd, busy and frame_count.
REQ-029 SHALL abort any frame when reset asserts mid-frame; gmii_tx_en SHALL be 0 on the clock after reset is sampled, and the CRC SHALL be reinitialised.
REQ-030 SHALL ignore cke while reset=1.

Verification
REQ-031 The bench SHALL cover: reset released, enable=1, cke=1, defaults -> gmii_tx_en high for 72 cycles; bytes 55x7, D5, FF x6, 00 00 0C 00 53 00, 88 B5, 00 00 00 00, 04 05 ...; IFG 12; frame_count=1.
REQ-032 The bench SHALL cover: the captured FCS of that frame -> matches a software CRC-32 over bytes 9..68; CRC over the whole frame after the SFD yields residue 32'hDEBB20E3.
REQ-033 The bench SHALL cover: enable held high for 3 frames -> exactly 12 idle slots between frames, payload bytes 0..3 = 0, 1, 2 in turn, frame_count=3.
REQ-034 The bench SHALL cover: enable dropped during PAYLOAD -> frame completes with a valid FCS, then IDLE and busy=0 after the 12 IFG slots.
REQ-035 The bench SHALL cover: cke toggling 1-in-10 -> identical byte sequence to the cke=1 run, with each byte held for 10 clk.
REQ-036 The bench SHALL cover: reset asserted at payload byte 20 -> gmii_tx_en=0 next clk, frame_count=0; the next frame starts with a clean preamble and the correct FCS.

Source files
------------

// File: rtl/ether_tx_frame_gen.sv
// GMII Ethernet frame generator: preamble, SFD, fixed header, counter payload, CRC-32 FCS, IFG.
// One byte slot per cke; outputs are registered from the next-state decode so the first byte lands on the starting edge.
module ether_tx_frame_gen #(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h00_00_0C_00_53_00,
    parameter logic [15:0] ETHER_TYPE  = 16'h88B5,
    parameter int unsigned PAYLOAD_LEN = 46,
    parameter int unsigned IFG_LEN     = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        enable,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        busy,
    output logic [31:0] frame_count
);

    localparam int unsigned CNT_W = 11;
    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHER_TYPE};

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        crc_q, crc_d;
    logic [31:0]        fc_q, fc_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         txd_q, txd_d;
    logic               busy_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Next slot: state/count, then the byte that slot carries and the CRC/frame-count updates it implies.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        crc_d   = crc_q;
        fc_d    = fc_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = PREAMBLE;
            end
            PREAMBLE: if (cnt_q == CNT_W'(6)) begin
                state_d = SFD;
                cnt_d   = '0;
            end
            SFD: begin
                state_d = HEADER;
                cnt_d   = '0;
            end
            HEADER: if (cnt_q == CNT_W'(13)) begin
                state_d = PAYLOAD;
                cnt_d   = '0;
            end
            PAYLOAD: if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
                state_d = FCS;
                cnt_d   = '0;
            end
            FCS: if (cnt_q == CNT_W'(3)) begin
                state_d = IFG;
                cnt_d   = '0;
            end
            IFG: if (cnt_q == CNT_W'(IFG_LEN - 1)) begin
                state_d = enable ? PREAMBLE : IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h55;
            end
            SFD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'hD5;
            end
            HEADER: begin
                tx_en_d = 1'b1;
                txd_d   = 8'(HDR >> (8 * (13 - int'(cnt_d[3:0]))));
            end
            PAYLOAD: begin
                tx_en_d = 1'b1;
                if (cnt_d < CNT_W'(4)) txd_d = 8'(fc_q >> (8 * (3 - int'(cnt_d[1:0]))));
                else                   txd_d = cnt_d[7:0];
            end
            FCS: begin
                tx_en_d = 1'b1;
                txd_d   = 8'(~crc_q >> (8 * int'(cnt_d[1:0])));
            end
            default: ;
        endcase

        // CRC restarts at every preamble and accumulates only header and payload bytes.
        if (state_d == PREAMBLE) crc_d = 32'hFFFF_FFFF;
        else if (state_d == HEADER || state_d == PAYLOAD) crc_d = crc_byte(crc_q, txd_d);

        if (state_d == FCS && cnt_d == CNT_W'(3)) fc_d = fc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            fc_q    <= 32'h0;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else if (cke) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            fc_q    <= fc_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign gmii_tx_en  = tx_en_q;
    assign gmii_txd    = txd_q;
    assign busy        = busy_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_ether_tx_frame_gen.sv
// Self-checking bench for ether_tx_frame_gen: records every cke slot and compares frames
// against a byte-array frame model built from the frame format rules.
module tb_ether_tx_frame_gen;

    localparam int PLEN = 46;
    localparam int FLEN = 26 + PLEN;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b0;
    logic        enable = 1'b0;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        busy;
    logic [31:0] frame_count;

    always #4 clk = ~clk;

    ether_tx_frame_gen dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .enable      (enable),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 1;
    int div_cnt  = 0;
    bit cke_off  = 1'b0;
    int hold_err = 0;
    int run_len  = 0;

    logic [7:0]  rec_d[$];
    bit          rec_en[$];
    bit          rec_busy[$];
    logic [31:0] rec_fc[$];
    int          fr_start[$];
    int          fr_len[$];
    logic [7:0]  exp_q[$];

    // One clock; slots (clock edges with cke=1) are recorded, other cycles must hold outputs.
    task automatic tick();
        logic       pen;
        logic [7:0] pd;
        cke = !cke_off && (div_cnt == 0);
        div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
        pen = gmii_tx_en;
        pd  = gmii_txd;
        @(posedge clk);
        #1;
        if (reset) begin
            run_len = 0;
        end else if (cke) begin
            rec_en.push_back(gmii_tx_en);
            rec_d.push_back(gmii_txd);
            rec_busy.push_back(busy);
            rec_fc.push_back(frame_count);
            run_len = gmii_tx_en ? run_len + 1 : 0;
        end else if (gmii_tx_en !== pen || gmii_txd !== pd) begin
            hold_err++;
        end
    endtask

    task automatic clear_rec();
        rec_d.delete(); rec_en.delete(); rec_busy.delete(); rec_fc.delete();
        hold_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        div_cnt = 0;
        tick(); tick();
        reset = 1'b0;
        clear_rec();
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Whole expected frame as bytes, preamble through FCS.
    function automatic void build_expected(input logic [31:0] fc);
        logic [111:0] h;
        logic [31:0]  c;
        h = {48'hFF_FF_FF_FF_FF_FF, 48'h00_00_0C_00_53_00, 16'h88B5};
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 14; k++) exp_q.push_back(h[111 - 8*k -: 8]);
        for (int i = 0; i < PLEN; i++) begin
            if (i < 4) exp_q.push_back(fc[31 - 8*i -: 8]);
            else       exp_q.push_back(8'(i));
        end
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 22 + PLEN; i++) c = crc_step(c, exp_q[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endfunction

    function automatic void parse();
        bit prev;
        prev = 1'b0;
        fr_start.delete(); fr_len.delete();
        for (int i = 0; i < rec_en.size(); i++) begin
            if (rec_en[i] && !prev) begin
                fr_start.push_back(i);
                fr_len.push_back(0);
            end
            if (rec_en[i]) fr_len[fr_len.size()-1] = fr_len[fr_len.size()-1] + 1;
            prev = rec_en[i];
        end
    endfunction

    function automatic int frame_errs(input int f, input logic [31:0] fc);
        int e;
        e = 0;
        build_expected(fc);
        if (fr_len[f] != FLEN) e++;
        for (int k = 0; k < FLEN; k++) begin
            if (fr_start[f] + k >= rec_d.size()) e++;
            else if (rec_d[fr_start[f] + k] !== exp_q[k]) e++;
        end
        return e;
    endfunction

    // Number of busy slots after the last FCS byte before busy drops.
    function automatic int busy_tail(input int f);
        int last;
        last = fr_start[f] + fr_len[f] - 1;
        for (int j = last + 1; j < rec_busy.size(); j++) if (!rec_busy[j]) return j - last - 1;
        return -1;
    endfunction

    task automatic run_one(input int drop_at, input int max_ticks, output bit timed_out);
        do_reset();
        enable = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < max_ticks; i++) begin
            tick();
            if (run_len >= drop_at) enable = 1'b0;
            if (!enable && frame_count == 32'd1 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3 * div) tick();
    endtask

    task automatic test_reset();
        div = 1; cke_off = 1'b0; enable = 1'b0; reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en got %b want 0", gmii_tx_en); end
        n_checks++; if (gmii_txd !== 8'h00) begin n_fail++; $display("FAIL rst_txd got %h want 00", gmii_txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rst_fc got %0d want 0", frame_count); end
        reset = 1'b0; enable = 1'b1;
        repeat (30) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got %b want 1", busy); end
        reset = 1'b1; cke_off = 1'b1;
        tick();
        n_checks++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_nocke_tx_en got %b want 0", gmii_tx_en); end
        n_checks++; if (gmii_txd !== 8'h00) begin n_fail++; $display("FAIL rst_nocke_txd got %h want 00", gmii_txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_nocke_busy got %b want 0", busy); end
        cke_off = 1'b0; enable = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        bit          to;
        logic [31:0] c, fcs;
        int          b;
        div = 1;
        run_one(1, 400, to);
        parse();
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout got timeout want done"); end
        n_checks++; if (rec_en.size() == 0 || rec_en[0] !== 1'b1) begin n_fail++; $display("FAIL single_latency got first slot not a frame byte want tx_en=1"); end
        n_checks++; if (fr_start.size() != 1) begin n_fail++; $display("FAIL single_nframes got %0d want 1", fr_start.size()); end
        if (fr_start.size() > 0) begin
            n_checks++; if (fr_len[0] != FLEN) begin n_fail++; $display("FAIL single_len got %0d want %0d", fr_len[0], FLEN); end
            n_checks++; if (frame_errs(0, 32'd0) != 0) begin n_fail++; $display("FAIL single_bytes got %0d bad bytes want 0", frame_errs(0, 32'd0)); end
            b = fr_start[0];
            if (b + FLEN <= rec_d.size()) begin
                c = 32'hFFFF_FFFF;
                for (int i = 8; i < 22 + PLEN; i++) c = crc_step(c, rec_d[b + i]);
                fcs = {rec_d[b+FLEN-1], rec_d[b+FLEN-2], rec_d[b+FLEN-3], rec_d[b+FLEN-4]};
                n_checks++; if (fcs !== ~c) begin n_fail++; $display("FAIL single_fcs got %h want %h", fcs, ~c); end
                c = 32'hFFFF_FFFF;
                for (int i = 8; i < FLEN; i++) c = crc_step(c, rec_d[b + i]);
                n_checks++; if (c !== 32'hDEBB20E3) begin n_fail++; $display("FAIL single_residue got %h want debb20e3", c); end
                n_checks++; if (rec_fc[b+FLEN-1] !== 32'd1) begin n_fail++; $display("FAIL single_fc_at_fcs got %0d want 1", rec_fc[b+FLEN-1]); end
            end
            n_checks++; if (busy_tail(0) != 12) begin n_fail++; $display("FAIL single_ifg got %0d want 12", busy_tail(0)); end
        end
        n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL single_fc got %0d want 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        bit to;
        div = 1;
        do_reset();
        enable = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (frame_count == 32'd2 && run_len == 1) enable = 1'b0;
            if (frame_count == 32'd3 && !busy) begin to = 1'b0; break; end
        end
        parse();
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout got timeout want done"); end
        n_checks++; if (fr_start.size() != 3) begin n_fail++; $display("FAIL b2b_nframes got %0d want 3", fr_start.size()); end
        if (fr_start.size() == 3) begin
            for (int f = 0; f < 3; f++) begin
                n_checks++; if (frame_errs(f, 32'(f)) != 0) begin n_fail++; $display("FAIL b2b_frame%0d got %0d bad bytes want 0", f, frame_errs(f, 32'(f))); end
            end
            for (int f = 0; f < 2; f++) begin
                n_checks++;
                if (fr_start[f+1] - fr_start[f] - fr_len[f] != 12) begin
                    n_fail++; $display("FAIL b2b_gap%0d got %0d want 12", f, fr_start[f+1] - fr_start[f] - fr_len[f]);
                end
            end
        end
        n_checks++; if (frame_count !== 32'd3) begin n_fail++; $display("FAIL b2b_fc got %0d want 3", frame_count); end
    endtask

    task automatic test_enable_drop();
        bit to;
        int at;
        div = 1;
        at = 23 + int'($urandom_range(0, PLEN - 2));
        run_one(at, 400, to);
        parse();
        n_checks++; if (to) begin n_fail++; $display("FAIL drop_timeout got timeout want done"); end
        n_checks++; if (fr_start.size() != 1) begin n_fail++; $display("FAIL drop_nframes got %0d want 1", fr_start.size()); end
        if (fr_start.size() > 0) begin
            n_checks++; if (frame_errs(0, 32'd0) != 0) begin n_fail++; $display("FAIL drop_bytes got %0d bad bytes want 0", frame_errs(0, 32'd0)); end
            n_checks++; if (busy_tail(0) != 12) begin n_fail++; $display("FAIL drop_ifg got %0d want 12", busy_tail(0)); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b want 0", busy); end
    endtask

    task automatic test_cke_div();
        bit to;
        div = 10;
        run_one(1, 4000, to);
        parse();
        n_checks++; if (to) begin n_fail++; $display("FAIL ckediv_timeout got timeout want done"); end
        n_checks++; if (rec_en.size() == 0 || rec_en[0] !== 1'b1) begin n_fail++; $display("FAIL ckediv_latency got first slot not a frame byte want tx_en=1"); end
        n_checks++; if (fr_start.size() != 1) begin n_fail++; $display("FAIL ckediv_nframes got %0d want 1", fr_start.size()); end
        if (fr_start.size() > 0) begin
            n_checks++; if (frame_errs(0, 32'd0) != 0) begin n_fail++; $display("FAIL ckediv_bytes got %0d bad bytes want 0", frame_errs(0, 32'd0)); end
            n_checks++; if (busy_tail(0) != 12) begin n_fail++; $display("FAIL ckediv_ifg got %0d want 12", busy_tail(0)); end
        end
        n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL ckediv_hold got %0d changes want 0", hold_err); end
        div = 1;
    endtask

    task automatic test_reset_mid();
        bit to;
        div = 1;
        do_reset();
        enable = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (frame_count == 32'd1 && run_len == 43) begin to = 1'b0; break; end
        end
        n_checks++; if (to) begin n_fail++; $display("FAIL rmid_timeout got timeout want payload byte 20"); end
        reset = 1'b1;
        tick();
        n_checks++; if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_en got %b want 0", gmii_tx_en); end
        n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rmid_fc got %0d want 0", frame_count); end
        reset = 1'b0;
        clear_rec();
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (run_len >= 1) enable = 1'b0;
            if (!enable && frame_count == 32'd1 && !busy) begin to = 1'b0; break; end
        end
        parse();
        n_checks++; if (to) begin n_fail++; $display("FAIL rmid_refr_timeout got timeout want done"); end
        n_checks++; if (fr_start.size() != 1) begin n_fail++; $display("FAIL rmid_nframes got %0d want 1", fr_start.size()); end
        if (fr_start.size() > 0) begin
            n_checks++; if (frame_errs(0, 32'd0) != 0) begin n_fail++; $display("FAIL rmid_bytes got %0d bad bytes want 0", frame_errs(0, 32'd0)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_enable_drop();
        test_cke_div();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
